// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process one
// operand bit per clock, with a START/DONE handshake and registered result flags.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic             SUB,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] SUM,
   output logic             CARRY,
   output logic             OVF
);

   localparam int unsigned     CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

   state_t           r_state, w_state_nx;
   logic [WIDTH-1:0] r_sa, r_sb, r_sr, r_sum;
   logic [WIDTH-1:0] w_sa_nx, w_sb_nx, w_sr_nx, w_sum_nx;
   logic [CW-1:0]    r_cnt, w_cnt_nx;
   logic             r_c, w_c_nx;
   logic             r_carry, w_carry_nx;
   logic             r_ovf, w_ovf_nx;
   logic             r_busy, r_done;
   logic             w_busy_nx, w_done_nx;
   logic             w_s, w_cout;

   assign w_s    = r_sa[0] ^ r_sb[0] ^ r_c;
   assign w_cout = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_c) | (r_sb[0] & r_c);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= IDLE;
         r_sa    <= '0;
         r_sb    <= '0;
         r_sr    <= '0;
         r_cnt   <= '0;
         r_c     <= 1'b0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_sa    <= w_sa_nx;
         r_sb    <= w_sb_nx;
         r_sr    <= w_sr_nx;
         r_cnt   <= w_cnt_nx;
         r_c     <= w_c_nx;
         r_sum   <= w_sum_nx;
         r_carry <= w_carry_nx;
         r_ovf   <= w_ovf_nx;
         r_busy  <= w_busy_nx;
         r_done  <= w_done_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_sa_nx    = r_sa;
      w_sb_nx    = r_sb;
      w_sr_nx    = r_sr;
      w_cnt_nx   = r_cnt;
      w_c_nx     = r_c;
      w_sum_nx   = r_sum;
      w_carry_nx = r_carry;
      w_ovf_nx   = r_ovf;
      case (r_state)
         IDLE, FIN: begin
            if (START) begin
               // Subtraction is A + ~B + 1: invert B and preload the carry with 1.
               w_sa_nx    = A;
               w_sb_nx    = SUB ? ~B : B;
               w_c_nx     = SUB;
               w_cnt_nx   = '0;
               w_state_nx = RUN;
            end else begin
               w_state_nx = IDLE;
            end
         end
         RUN: begin
            w_sa_nx  = r_sa >> 1;
            w_sb_nx  = r_sb >> 1;
            w_sr_nx  = {w_s, r_sr[WIDTH-1:1]};
            w_c_nx   = w_cout;
            w_cnt_nx = r_cnt + CW'(1);
            if (r_cnt == LAST) begin
               // Result regs load on the same edge as FIN entry, so they are valid with DONE.
               w_state_nx = FIN;
               w_cnt_nx   = r_cnt;
               w_sum_nx   = {w_s, r_sr[WIDTH-1:1]};
               w_carry_nx = w_cout;
               w_ovf_nx   = r_c ^ w_cout;
            end
         end
         default: w_state_nx = IDLE;
      endcase
      w_busy_nx = (w_state_nx == RUN);
      w_done_nx = (w_state_nx == FIN);
   end

   assign BUSY  = r_busy;
   assign DONE  = r_done;
   assign SUM   = r_sum;
   assign CARRY = r_carry;
   assign OVF   = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit instance with directed vectors and
// a 2-bit instance swept exhaustively against a signed/unsigned reference model.
module tb_serial_adder;

   typedef struct packed {
      logic [7:0] sum;
      logic       c;
      logic       o;
   } exp8_t;

   typedef struct packed {
      logic [1:0] sum;
      logic       c;
      logic       o;
   } exp2_t;

   typedef struct packed {
      logic       sub;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] sum;
      logic       c;
      logic       o;
   } vec_t;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       START8, SUB8, BUSY8, DONE8, CARRY8, OVF8;
   logic [7:0] A8, B8, SUM8;
   logic       START2, SUB2, BUSY2, DONE2, CARRY2, OVF2;
   logic [1:0] A2, B2, SUM2;

   exp8_t q8[$];
   exp2_t q2[$];
   int    dcyc[$];
   int    n_pass = 0, n_total = 0;
   int    cyc = 0, acc8 = 0, done8_cyc = 0;
   int    done8_cnt = 0, done2_cnt = 0, busy8_cnt = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .CLK(CLK), .RST_N(RST_N), .START(START8), .SUB(SUB8), .A(A8), .B(B8),
      .BUSY(BUSY8), .DONE(DONE8), .SUM(SUM8), .CARRY(CARRY8), .OVF(OVF8)
   );

   serial_adder #(.WIDTH(2)) u_dut2 (
      .CLK(CLK), .RST_N(RST_N), .START(START2), .SUB(SUB2), .A(A2), .B(B2),
      .BUSY(BUSY2), .DONE(DONE2), .SUM(SUM2), .CARRY(CARRY2), .OVF(OVF2)
   );

   function automatic void chk(input string name, input int unsigned act, input int unsigned exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endfunction

   always @(negedge CLK) begin
      exp8_t e;
      if (BUSY8) busy8_cnt++;
      if (DONE8) begin
         done8_cnt++;
         done8_cyc = cyc;
         dcyc.push_back(cyc);
         chk("busy_in_fin8", BUSY8, 0);
         if (q8.size() == 0) chk("unexpected_done8", 1, 0);
         else begin
            e = q8.pop_front();
            chk("sum8", SUM8, e.sum);
            chk("carry8", CARRY8, e.c);
            chk("ovf8", OVF8, e.o);
         end
      end
   end

   always @(negedge CLK) begin
      exp2_t e;
      if (DONE2) begin
         done2_cnt++;
         if (q2.size() == 0) chk("unexpected_done2", 1, 0);
         else begin
            e = q2.pop_front();
            chk("sum2", SUM2, e.sum);
            chk("carry2", CARRY2, e.c);
            chk("ovf2", OVF2, e.o);
         end
      end
   end

   task automatic start8(input logic s, input logic [7:0] a, input logic [7:0] b, input exp8_t e);
      q8.push_back(e);
      @(negedge CLK);
      START8 = 1'b1; SUB8 = s; A8 = a; B8 = b;
      acc8 = cyc + 1;
      @(negedge CLK);
      START8 = 1'b0; SUB8 = 1'($urandom); A8 = 8'($urandom); B8 = 8'($urandom);
   endtask

   task automatic wait8(input int target, input string name);
      int k = 0;
      while (done8_cnt < target && k < 60) begin
         @(negedge CLK); #1; k++;
      end
      chk(name, (done8_cnt >= target) ? 1 : 0, 1);
   endtask

   vec_t vecs[5] = '{
      '{1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0},
      '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0},
      '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1},
      '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1},
      '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0}
   };

   initial begin
      int b0, d0, n0, base;
      RST_N = 1'b0;
      START8 = 1'b0; SUB8 = 1'b0; A8 = '0; B8 = '0;
      START2 = 1'b0; SUB2 = 1'b0; A2 = '0; B2 = '0;
      repeat (3) @(negedge CLK);
      chk("reset_outs8", {BUSY8, DONE8, CARRY8, OVF8, SUM8}, 0);
      chk("reset_outs2", {BUSY2, DONE2, CARRY2, OVF2, SUM2}, 0);
      RST_N = 1'b1;
      @(negedge CLK);

      for (int i = 0; i < 5; i++) begin
         b0 = busy8_cnt;
         start8(vecs[i].sub, vecs[i].a, vecs[i].b, '{vecs[i].sum, vecs[i].c, vecs[i].o});
         wait8(i + 1, "done_timeout");
         if (i == 0) begin
            chk("busy_cycles", busy8_cnt - b0, 8);
            chk("done_latency", done8_cyc - acc8, 8);
         end
      end

      repeat (3) @(negedge CLK);
      chk("hold_sum", SUM8, 8'hFE);
      chk("hold_carry", CARRY8, 0);
      chk("idle_busy_done", {BUSY8, DONE8}, 0);

      // START during RUN must be ignored
      q8.push_back('{8'h03, 1'b0, 1'b0});
      @(negedge CLK);
      START8 = 1'b1; SUB8 = 1'b0; A8 = 8'h01; B8 = 8'h02;
      @(negedge CLK);
      START8 = 1'b0;
      repeat (3) @(negedge CLK);
      START8 = 1'b1; SUB8 = 1'b1; A8 = 8'h11; B8 = 8'h00;
      @(negedge CLK);
      START8 = 1'b0;
      wait8(6, "ignore_done_timeout");
      repeat (12) @(negedge CLK);
      chk("ignore_no_extra_done", done8_cnt, 6);

      // START held high: three back-to-back operations
      for (int i = 0; i < 3; i++) q8.push_back('{8'h23, 1'b0, 1'b0});
      n0 = dcyc.size();
      base = done8_cnt;
      @(negedge CLK);
      START8 = 1'b1; SUB8 = 1'b0; A8 = 8'h20; B8 = 8'h03;
      repeat (20) @(negedge CLK);
      START8 = 1'b0;
      wait8(base + 3, "held_done_timeout");
      repeat (12) @(negedge CLK);
      chk("held_count", done8_cnt, base + 3);
      if (dcyc.size() >= n0 + 3) begin
         chk("held_gap1", dcyc[n0+1] - dcyc[n0], 9);
         chk("held_gap2", dcyc[n0+2] - dcyc[n0+1], 9);
      end else chk("held_gaps", dcyc.size(), n0 + 3);

      // Reset mid-operation: no expectation queued, so any DONE is flagged
      @(negedge CLK);
      START8 = 1'b1; SUB8 = 1'b0; A8 = 8'hAA; B8 = 8'h55;
      @(negedge CLK);
      START8 = 1'b0;
      repeat (3) @(negedge CLK);
      d0 = done8_cnt;
      RST_N = 1'b0;
      #1;
      chk("midrst_outs", {BUSY8, DONE8, CARRY8, OVF8, SUM8}, 0);
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      repeat (12) @(negedge CLK);
      chk("abort_no_done", done8_cnt, d0);
      start8(1'b0, 8'h01, 8'h01, '{8'h02, 1'b0, 1'b0});
      wait8(d0 + 1, "post_reset_done_timeout");

      // WIDTH=2 exhaustive sweep
      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++) begin
               int sa, sb, r, u, k, tgt;
               exp2_t e;
               sa = (a >= 2) ? a - 4 : a;
               sb = (b >= 2) ? b - 4 : b;
               r  = (s != 0) ? sa - sb : sa + sb;
               u  = (s != 0) ? a + ((~b) & 3) + 1 : a + b;
               e.sum = 2'(u & 3);
               e.c   = 1'((u >> 2) & 1);
               e.o   = (r > 1 || r < -2) ? 1'b1 : 1'b0;
               q2.push_back(e);
               tgt = done2_cnt + 1;
               @(negedge CLK);
               START2 = 1'b1; SUB2 = 1'(s); A2 = 2'(a); B2 = 2'(b);
               @(negedge CLK);
               START2 = 1'b0;
               k = 0;
               while (done2_cnt < tgt && k < 20) begin
                  @(negedge CLK); #1; k++;
               end
               if (done2_cnt < tgt) chk("w2_done_timeout", 0, 1);
            end

      repeat (4) @(negedge CLK);
      chk("q8_drained", q8.size(), 0);
      chk("q2_drained", q2.size(), 0);
      chk("w2_op_count", done2_cnt, 32);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
